multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
Registered multi-cycle successor to the single-cycle 8-bit decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with memory and fetch handshakes. Opcode, register-address and shift-amount widths are parametrised. Sits between instruction register, register file, ALU and data memory; all control outputs are registered.

Parameters:
OPCODE_W, 3, opcode width; must be >= 3. Upper bits beyond bit 2 must be zero for a legal opcode.
REG_AW, 1, register-file address width (rs, rd, read/write selects).
SHAMT_W, 3, shift-amount / immediate field width.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction word present on opcode/rs/rd/shamt
opcode  input  OPCODE_W  instruction opcode
rs  input  REG_AW  source register
rd  input  REG_AW  destination/second register
shamt  input  SHAMT_W  shift amount / immediate
dmem_ready  input  1  data memory completes the current access this cycle
fetch_req  output  1  request next instruction
ir_load  output  1  latch instruction into IR
pc_inc  output  1  advance PC one instruction
reg_read1  output  REG_AW  register-file read select 1
reg_read2  output  REG_AW  register-file read select 2
reg_write_en  output  1  register-file write strobe (one cycle)
alu_op  output  OPCODE_W  ALU operation
alu_src  output  1  1 = register operand, 0 = address path
reg_dst  output  1  write-destination select (always 0 in this generation)
reg_wsrc  output  1  0 = ALU result, 1 = memory/shift path
ext_en  output  1  immediate extension enable
sign_ext  output  SHAMT_W  immediate/shamt to extender
mem_read  output  1  data memory read strobe
mem_write  output  1  data memory write strobe
busy  output  1  instruction in flight (state != FETCH)
illegal  output  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (async assert, sync release): state=FETCH; all outputs 0; latched fields 0.
- Opcodes (shared package, zero-extended to OPCODE_W): ADD=0, ADDI=4, SW=5, LW=6, SLL=7. Any other value is illegal.
- FETCH: fetch_req=1. On instr_valid: latch opcode/rs/rd/shamt, pulse ir_load and pc_inc, go to DECODE.
- DECODE (1 cycle): drive reg_read1=rs_q, reg_read2=rd_q, alu_op=opcode_q, sign_ext=shamt_q. Set alu_src/reg_wsrc/ext_en per opcode:
  - ADD: 1/0/0
  - ADDI: 1/0/1
  - SW: 0/1/1
  - LW: 0/1/1
  - SLL: 1/1/1
  - Illegal: pulse illegal, then go to FETCH.
  - Legal opcodes go to EXEC.
- EXEC (1 cycle): hold decode outputs. LW/SW go to MEM; all others go to WB.
- MEM: LW holds mem_read=1. SW holds mem_write=1 and mem_read=0 (the SW read strobe is intentionally dropped). Stay while dmem_ready=0. On dmem_ready: LW goes to WB, SW goes to FETCH. dmem_ready sampled outside MEM is ignored.
- WB: pulse reg_write_en for exactly one cycle, then go to FETCH.
- Latency (instr_valid to reg_write_en):
  - ADD/ADDI/SLL: 3 cycles
  - LW: 4 + memory wait cycles
- SW never asserts reg_write_en.
- fetch_req deasserts the cycle after acceptance. instr_valid outside FETCH is ignored.
- Reset mid-MEM drops mem_read/mem_write immediately (asynchronous).

Optional Feature:
PERF_COUNT_EN: adds outputs instr_count[31:0] and stall_count[31:0].
- instr_count increments on each retire: WB exit or SW MEM exit.
- stall_count increments each MEM cycle with dmem_ready=0.
- Both counters saturate at all-ones and reset to 0.
- Without the macro, neither port nor counter logic exists.

Decomposition:
- Package cu_pkg holds: opcode localparams; state enum (FETCH, DECODE, EXEC, MEM, WB); a decode struct {alu_src, reg_wsrc, ext_en, is_mem, is_store, legal}.
- One combinational sub-module, cu_decode_rom: maps opcode to the decode struct. The FSM registers its output.

Test Plan:
- Reset, then ADD rs=1 rd=0 shamt=3 → ir_load at +0, reg_write_en pulse at +3 with reg_read1=1, sign_ext=3, alu_src=1, ext_en=0.
- LW with dmem_ready low 2 cycles → mem_read high 3 cycles, reg_write_en at +6, reg_wsrc=1.
- SW with dmem_ready immediate → mem_write 1 cycle, mem_read=0, no reg_write_en, back to FETCH at +4.
- opcode=3 (OPCODE_W=4: opcode=8) → illegal pulse in DECODE, no mem or write strobes, fetch_req at +2.
- rst_n low mid-MEM of LW → mem_read drops same cycle; after release state=FETCH, all outputs 0.
- PERF_COUNT_EN: ADD, LW (3-cycle stall), SW → instr_count=3, stall_count=3.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared opcode map, FSM state encoding and decode record for multicycle_control_unit.
package cu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_LW   = 3'd6;
  localparam logic [2:0] OP_SLL  = 3'd7;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic alu_src;
    logic reg_wsrc;
    logic ext_en;
    logic is_mem;
    logic is_store;
    logic legal;
  } dec_t;

  localparam dec_t DEC_NONE = '0;

  // Builds a decode record for a defined opcode.
  function automatic dec_t make_dec(input logic alu_src, input logic reg_wsrc,
                                    input logic ext_en, input logic is_mem,
                                    input logic is_store);
    dec_t d;
    d.alu_src  = alu_src;
    d.reg_wsrc = reg_wsrc;
    d.ext_en   = ext_en;
    d.is_mem   = is_mem;
    d.is_store = is_store;
    d.legal    = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/cu_decode_rom.sv
// Combinational opcode-to-control decode table; upper opcode bits must be zero
// for a match, so any non-zero upper bit decodes as illegal.
module cu_decode_rom
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output dec_t                dec
);

  localparam logic [OPCODE_W-1:0] ADD_C  = OPCODE_W'(OP_ADD);
  localparam logic [OPCODE_W-1:0] ADDI_C = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] SW_C   = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] LW_C   = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] SLL_C  = OPCODE_W'(OP_SLL);

  // Decode table: alu_src, reg_wsrc, ext_en, is_mem, is_store.
  always_comb begin
    dec = DEC_NONE;
    case (opcode)
      ADD_C:   dec = make_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ADDI_C:  dec = make_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      SW_C:    dec = make_dec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      LW_C:    dec = make_dec(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      SLL_C:   dec = make_dec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      default: dec = DEC_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with registered outputs.
// Optional PERF_COUNT_EN macro adds saturating retire and memory-stall counters.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int REG_AW   = 1,
  parameter int SHAMT_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_AW-1:0]   rs,
  input  logic [REG_AW-1:0]   rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic                dmem_ready,
  output logic                fetch_req,
  output logic                ir_load,
  output logic                pc_inc,
  output logic [REG_AW-1:0]   reg_read1,
  output logic [REG_AW-1:0]   reg_read2,
  output logic                reg_write_en,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                reg_wsrc,
  output logic                ext_en,
  output logic [SHAMT_W-1:0]  sign_ext,
  output logic                mem_read,
  output logic                mem_write,
  output logic                busy,
  output logic                illegal
`ifdef PERF_COUNT_EN
  ,
  output logic [31:0]         instr_count,
  output logic [31:0]         stall_count
`endif
);

  state_t              state_r, state_s;
  logic [OPCODE_W-1:0] opcode_r, op_s;
  logic [REG_AW-1:0]   rs_r, rs_s, rd_r, rd_s;
  logic [SHAMT_W-1:0]  shamt_r, shamt_s;
  dec_t                dec_r, dec_s, rom_dec_s;
  logic                accept_s;

  logic                fetch_req_s, ir_load_s, pc_inc_s, reg_write_en_s;
  logic [REG_AW-1:0]   reg_read1_s, reg_read2_s;
  logic [OPCODE_W-1:0] alu_op_s;
  logic                alu_src_s, reg_wsrc_s, ext_en_s;
  logic [SHAMT_W-1:0]  sign_ext_s;
  logic                mem_read_s, mem_write_s, busy_s, illegal_s;

  // Decode the incoming opcode so the record can be captured at acceptance.
  cu_decode_rom #(.OPCODE_W(OPCODE_W)) u_decode_rom (
    .opcode (opcode),
    .dec    (rom_dec_s)
  );

  // Next-state logic; instr_valid and dmem_ready only matter in FETCH and MEM.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      FETCH: begin
        if (instr_valid) begin
          accept_s = 1'b1;
          state_s  = DECODE;
        end else begin
          state_s  = FETCH;
        end
      end
      DECODE: begin
        if (dec_r.legal) state_s = EXEC;
        else             state_s = FETCH;
      end
      EXEC: begin
        if (dec_r.is_mem) state_s = MEM;
        else              state_s = WB;
      end
      MEM: begin
        if (!dmem_ready)         state_s = MEM;
        else if (dec_r.is_store) state_s = FETCH;
        else                     state_s = WB;
      end
      WB:      state_s = FETCH;
      default: state_s = FETCH;
    endcase
  end

  // Instruction fields as they will be held next cycle.
  always_comb begin
    if (accept_s) begin
      op_s    = opcode;
      rs_s    = rs;
      rd_s    = rd;
      shamt_s = shamt;
      dec_s   = rom_dec_s;
    end else begin
      op_s    = opcode_r;
      rs_s    = rs_r;
      rd_s    = rd_r;
      shamt_s = shamt_r;
      dec_s   = dec_r;
    end
  end

  // Output values computed from the next state so they line up with it once registered.
  always_comb begin
    fetch_req_s    = 1'b0;
    busy_s         = 1'b0;
    alu_op_s       = '0;
    reg_read1_s    = '0;
    reg_read2_s    = '0;
    sign_ext_s     = '0;
    alu_src_s      = 1'b0;
    reg_wsrc_s     = 1'b0;
    ext_en_s       = 1'b0;
    if (state_s == FETCH) begin
      fetch_req_s  = 1'b1;
    end else begin
      busy_s       = 1'b1;
      alu_op_s     = op_s;
      reg_read1_s  = rs_s;
      reg_read2_s  = rd_s;
      sign_ext_s   = shamt_s;
      alu_src_s    = dec_s.alu_src;
      reg_wsrc_s   = dec_s.reg_wsrc;
      ext_en_s     = dec_s.ext_en;
    end
    ir_load_s      = accept_s;
    pc_inc_s       = accept_s;
    illegal_s      = accept_s && !rom_dec_s.legal;
    reg_write_en_s = (state_s == WB);
    // A store never raises the read strobe, even though it is a memory op.
    mem_read_s     = (state_s == MEM) && dec_s.is_mem && !dec_s.is_store;
    mem_write_s    = (state_s == MEM) && dec_s.is_store;
  end

  // State, held instruction fields and every control output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FETCH;
      opcode_r     <= '0;
      rs_r         <= '0;
      rd_r         <= '0;
      shamt_r      <= '0;
      dec_r        <= DEC_NONE;
      fetch_req    <= 1'b0;
      ir_load      <= 1'b0;
      pc_inc       <= 1'b0;
      reg_read1    <= '0;
      reg_read2    <= '0;
      reg_write_en <= 1'b0;
      alu_op       <= '0;
      alu_src      <= 1'b0;
      reg_dst      <= 1'b0;
      reg_wsrc     <= 1'b0;
      ext_en       <= 1'b0;
      sign_ext     <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      busy         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      state_r      <= state_s;
      opcode_r     <= op_s;
      rs_r         <= rs_s;
      rd_r         <= rd_s;
      shamt_r      <= shamt_s;
      dec_r        <= dec_s;
      fetch_req    <= fetch_req_s;
      ir_load      <= ir_load_s;
      pc_inc       <= pc_inc_s;
      reg_read1    <= reg_read1_s;
      reg_read2    <= reg_read2_s;
      reg_write_en <= reg_write_en_s;
      alu_op       <= alu_op_s;
      alu_src      <= alu_src_s;
      reg_dst      <= 1'b0;
      reg_wsrc     <= reg_wsrc_s;
      ext_en       <= ext_en_s;
      sign_ext     <= sign_ext_s;
      mem_read     <= mem_read_s;
      mem_write    <= mem_write_s;
      busy         <= busy_s;
      illegal      <= illegal_s;
    end
  end

`ifdef PERF_COUNT_EN
  logic retire_s, stall_s;

  assign retire_s = (state_r == WB) || ((state_r == MEM) && dmem_ready && dec_r.is_store);
  assign stall_s  = (state_r == MEM) && !dmem_ready;

  // Saturating retire and memory-wait counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (retire_s && (instr_count != 32'hFFFF_FFFF)) instr_count <= instr_count + 32'd1;
      if (stall_s && (stall_count != 32'hFFFF_FFFF)) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
